fpu_mul_arb: RTL and testbench
==============================

FPU_MUL_ARB -- requirements
Module: fpu_mul_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one fpuMul16; legal range 2..8.
REQ-002 Parameter TIMEOUT_CYC, default 64: watchdog limit in cycles, used only when FPU_ARB_TIMEOUT_EN is defined.
REQ-003 Port clock, input, 1: single clock; all state updates on posedge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port reqValid, input, NUM_REQ: per-requester operation request, held until granted.
REQ-006 Port reqIn1, input, NUM_REQ x fp16_t: per-requester operand 1, stable while reqValid is 1.
REQ-007 Port reqIn2, input, NUM_REQ x fp16_t: per-requester operand 2, stable while reqValid is 1.
REQ-008 Port reqGrant, output, NUM_REQ: one-hot, one-cycle pulse; operands accepted this cycle.
REQ-009 Port respValid, output, NUM_REQ: one-hot, one-cycle pulse; result returned to that requester.
REQ-010 Port respOut, output, fp16_t: result product, valid while any respValid bit is 1.
REQ-011 Port respCondCodes, output, condCode_t: multiplier condition codes for the response.
REQ-012 Port respStatus, output, opStatusFlag_t: multiplier status flags for the response.
REQ-013 Port respTimeout, output, 1: response produced by the watchdog, not by the multiplier.
REQ-014 Ports mulStart (out, 1), mulIn1 and mulIn2 (out, fp16_t): drive fpuMul16 start, fpuIn1 and fpuIn2.
REQ-015 Ports mulDone (in, 1), mulOut (in, fp16_t), mulCondCodes (in, condCode_t), mulStatus (in, opStatusFlag_t): fpuMul16 done, fpuOut, condCodes and opStatusFlags.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, RESP; one operation is in flight at most.
REQ-017 IDLE: if any reqValid bit is 1, grant the first set bit at or above rrPtr (wrapping modulo NUM_REQ), pulse that reqGrant bit, latch both operands and the grant index, and go to ISSUE. Otherwise stay in IDLE.
REQ-018 ISSUE: assert mulStart for exactly one cycle with the latched operands, then go to WAIT.
REQ-019 mulIn1 and mulIn2 hold the latched operands from ISSUE through WAIT, and are 0 otherwise.
REQ-020 WAIT: when mulDone is sampled 1, register mulOut, mulCondCodes and mulStatus, and go to RESP. mulDone is ignored in every other state.
REQ-021 RESP: assert respValid[grant] for one cycle with the registered result; set rrPtr = (grant+1) mod NUM_REQ; return to IDLE.
REQ-022 Outside RESP, respValid is all-zero and respOut, respCondCodes, respStatus and respTimeout are 0.
REQ-023 Latency: grant in cycle G, mulStart in G+1, respValid in the cycle after mulDone is sampled. The earliest next grant is the cycle after RESP.
REQ-024 Fairness: a continuously asserted request is granted within NUM_REQ-1 intervening operations.
REQ-025 A request deasserted before its grant is dropped with no response.
REQ-026 Requests that change during WAIT do not affect the in-flight operation.

Reset
REQ-027 When reset is 1 at a clock edge: state goes to IDLE, rrPtr = 0, the watchdog counter = 0, and all outputs are 0 on the next cycle. This holds in any state, including mid-WAIT; the in-flight operation is discarded with no response.
REQ-028 The multiplier shares the same reset. A mulDone arriving after reset is ignored.

Configuration
REQ-029 Macro FPU_ARB_TIMEOUT_EN defined: WAIT counts cycles. If TIMEOUT_CYC cycles elapse without mulDone, the block goes to RESP with respOut = 16'h7E00 (qNaN), respCondCodes = 0, respStatus = 0 and respTimeout = 1.
REQ-030 FPU_ARB_TIMEOUT_EN undefined: WAIT waits indefinitely for mulDone, no counter logic is built, and respTimeout is tied to 0.

Verification
REQ-031 Single request: reqValid = 4'b0001, operands 3C00 and 4000 -> reqGrant[0] pulse, mulStart one cycle later, respValid[0] with respOut = 4000.
REQ-032 Contention: reqValid = 4'b1111 held with rrPtr = 0 -> grant order 0,1,2,3,0; each requester receives its own product.
REQ-033 Wrap-around: rrPtr = 3 with reqValid = 4'b1001 -> requester 3 granted first, then requester 0.
REQ-034 Reset in WAIT: reset pulse while mulDone is pending -> no respValid, state IDLE, rrPtr = 0, and the next grant goes to the lowest set requester.
REQ-035 Timeout (FPU_ARB_TIMEOUT_EN defined, mulDone tied 0) -> respValid after 64 WAIT cycles with respOut = 7E00 and respTimeout = 1. With the macro undefined -> no response ever.
REQ-036 Stray mulDone pulsed in IDLE -> no respValid, state unchanged.

Source files
------------

// File: rtl/fpu_mul_arb.sv
// fpu_mul_arb: round-robin arbiter that shares one fpuMul16 among NUM_REQ
// requesters. One operation is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Optional watchdog: define FPU_ARB_TIMEOUT_EN to build a WAIT-state timeout
// that returns a qNaN response flagged with respTimeout.
// Widths: fp16 values are 16 bits, condition codes 4 bits, status flags 5 bits.
`timescale 1ns/1ps

module fpu_mul_arb #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      reqValid,
  input  logic [NUM_REQ-1:0][15:0] reqIn1,
  input  logic [NUM_REQ-1:0][15:0] reqIn2,
  output logic [NUM_REQ-1:0]      reqGrant,
  output logic [NUM_REQ-1:0]      respValid,
  output logic [15:0]             respOut,
  output logic [3:0]              respCondCodes,
  output logic [4:0]              respStatus,
  output logic                    respTimeout,
  output logic                    mulStart,
  output logic [15:0]             mulIn1,
  output logic [15:0]             mulIn2,
  input  logic                    mulDone,
  input  logic [15:0]             mulOut,
  input  logic [3:0]              mulCondCodes,
  input  logic [4:0]              mulStatus
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam logic [IDX_W:0] NUM_REQ_W = (IDX_W+1)'(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t            state_reg, state_next;
  logic [IDX_W-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [IDX_W-1:0]  grant_idx_reg, grant_idx_next;
  logic [15:0]       op1_reg, op1_next;
  logic [15:0]       op2_reg, op2_next;
  logic [15:0]       res_reg, res_next;
  logic [3:0]        cc_reg, cc_next;
  logic [4:0]        st_reg, st_next;

  // Candidate requesters in search order, starting at rr_ptr and wrapping.
  logic [IDX_W-1:0]  cand_idx [NUM_REQ];
  logic [NUM_REQ-1:0] cand_valid;
  logic              pick_found;
  logic [IDX_W-1:0]  pick_idx;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      logic [IDX_W:0] sum;
      assign sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      // sum < 2*NUM_REQ, so a single conditional subtract is the modulo.
      assign cand_idx[gi]   = (sum >= NUM_REQ_W) ? IDX_W'(sum - NUM_REQ_W) : sum[IDX_W-1:0];
      assign cand_valid[gi] = reqValid[cand_idx[gi]];
    end
  endgenerate

  // Priority pick: lowest search offset with a valid request wins.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (cand_valid[i]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wd_cnt_reg, wd_cnt_next;
  logic            tmo_reg, tmo_next;

  // Watchdog counter and timeout flag registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt_reg <= '0;
      tmo_reg    <= 1'b0;
    end else begin
      wd_cnt_reg <= wd_cnt_next;
      tmo_reg    <= tmo_next;
    end
  end
`else
  // Constant 0 for any legal TIMEOUT_CYC; referencing the parameter keeps it
  // in use when the watchdog is not built.
  assign respTimeout = (TIMEOUT_CYC < 0);
`endif

  // Next-state logic and all outputs; outputs default to zero.
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_idx_next = grant_idx_reg;
    op1_next       = op1_reg;
    op2_next       = op2_reg;
    res_next       = res_reg;
    cc_next        = cc_reg;
    st_next        = st_reg;
    reqGrant       = '0;
    respValid      = '0;
    respOut        = '0;
    respCondCodes  = '0;
    respStatus     = '0;
    mulStart       = 1'b0;
    mulIn1         = '0;
    mulIn2         = '0;
`ifdef FPU_ARB_TIMEOUT_EN
    wd_cnt_next    = wd_cnt_reg;
    tmo_next       = tmo_reg;
    respTimeout    = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        // No grant while reset is held: the latched operands would be discarded.
        if (pick_found && !reset) begin
          reqGrant[pick_idx] = 1'b1;
          grant_idx_next     = pick_idx;
          op1_next           = reqIn1[pick_idx];
          op2_next           = reqIn2[pick_idx];
          state_next         = S_ISSUE;
        end
      end
      S_ISSUE: begin
        mulStart   = 1'b1;
        mulIn1     = op1_reg;
        mulIn2     = op2_reg;
        state_next = S_WAIT;
`ifdef FPU_ARB_TIMEOUT_EN
        wd_cnt_next = '0;
`endif
      end
      S_WAIT: begin
        mulIn1 = op1_reg;
        mulIn2 = op2_reg;
        if (mulDone) begin
          res_next   = mulOut;
          cc_next    = mulCondCodes;
          st_next    = mulStatus;
          state_next = S_RESP;
`ifdef FPU_ARB_TIMEOUT_EN
          tmo_next   = 1'b0;
        end else if (wd_cnt_reg == WD_W'(TIMEOUT_CYC - 1)) begin
          res_next   = 16'h7E00;
          cc_next    = '0;
          st_next    = '0;
          tmo_next   = 1'b1;
          state_next = S_RESP;
        end else begin
          wd_cnt_next = wd_cnt_reg + 1'b1;
`endif
        end
      end
      S_RESP: begin
        respValid[grant_idx_reg] = 1'b1;
        respOut       = res_reg;
        respCondCodes = cc_reg;
        respStatus    = st_reg;
`ifdef FPU_ARB_TIMEOUT_EN
        respTimeout   = tmo_reg;
`endif
        rr_ptr_next   = (grant_idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_reg + 1'b1;
        state_next    = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, pointer and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      rr_ptr_reg    <= '0;
      grant_idx_reg <= '0;
      op1_reg       <= '0;
      op2_reg       <= '0;
      res_reg       <= '0;
      cc_reg        <= '0;
      st_reg        <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_idx_reg <= grant_idx_next;
      op1_reg       <= op1_next;
      op2_reg       <= op2_next;
      res_reg       <= res_next;
      cc_reg        <= cc_next;
      st_reg        <= st_next;
    end
  end

endmodule

// File: tb/tb_fpu_mul_arb.sv
// tb_fpu_mul_arb: directed bench for fpu_mul_arb; the bench plays the role of
// the multiplier and supplies hand-computed fp16 products.
`timescale 1ns/1ps

module tb_fpu_mul_arb;
  localparam int N = 4;

  logic               clock = 1'b0;
  logic               reset;
  logic [N-1:0]       reqValid;
  logic [N-1:0][15:0] reqIn1, reqIn2;
  logic [N-1:0]       reqGrant, respValid;
  logic [15:0]        respOut;
  logic [3:0]         respCondCodes;
  logic [4:0]         respStatus;
  logic               respTimeout;
  logic               mulStart;
  logic [15:0]        mulIn1, mulIn2;
  logic               mulDone;
  logic [15:0]        mulOut;
  logic [3:0]         mulCondCodes;
  logic [4:0]         mulStatus;

  int pass_cnt = 0;
  int total_cnt = 0;

  fpu_mul_arb #(.NUM_REQ(N), .TIMEOUT_CYC(64)) dut (
    .clock(clock), .reset(reset), .reqValid(reqValid), .reqIn1(reqIn1), .reqIn2(reqIn2),
    .reqGrant(reqGrant), .respValid(respValid), .respOut(respOut),
    .respCondCodes(respCondCodes), .respStatus(respStatus), .respTimeout(respTimeout),
    .mulStart(mulStart), .mulIn1(mulIn1), .mulIn2(mulIn2), .mulDone(mulDone),
    .mulOut(mulOut), .mulCondCodes(mulCondCodes), .mulStatus(mulStatus)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    @(posedge clock); #1;
    reset = 1'b1; reqValid = '0; mulDone = 1'b0; mulOut = '0; mulCondCodes = '0; mulStatus = '0;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  // Returns at the negedge of the grant cycle, or after a bounded wait.
  task automatic wait_grant(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (reqGrant != '0) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Multiplier reply: done pulse for one cycle; returns just after the RESP edge.
  task automatic pulse_done(input logic [15:0] o, input logic [3:0] c, input logic [4:0] s);
    @(posedge clock); #1;
    mulDone = 1'b1; mulOut = o; mulCondCodes = c; mulStatus = s;
    @(posedge clock); #1;
    mulDone = 1'b0; mulOut = '0; mulCondCodes = '0; mulStatus = '0;
  endtask

  task automatic test_reset();
    @(posedge clock); #1;
    reset = 1'b1; reqValid = 4'hF; reqIn1 = '0; reqIn2 = '0; mulDone = 1'b1;
    mulOut = 16'hFFFF; mulCondCodes = 4'hF; mulStatus = 5'h1F;
    repeat (2) @(posedge clock);
    @(negedge clock);
    total_cnt++;
    if ({reqGrant, respValid, mulStart} !== 9'd0)
      $display("FAIL reset_held_ctrl: got %b want 0", {reqGrant, respValid, mulStart});
    else pass_cnt++;
    @(posedge clock); #1;
    reset = 1'b0; reqValid = '0; mulDone = 1'b0; mulOut = '0; mulCondCodes = '0; mulStatus = '0;
    @(negedge clock);
    total_cnt++;
    if ({reqGrant, respValid, mulStart, mulIn1, mulIn2, respOut, respCondCodes, respStatus, respTimeout} !== '0)
      $display("FAIL reset_outputs: got %h want 0",
               {reqGrant, respValid, mulStart, mulIn1, mulIn2, respOut, respCondCodes, respStatus, respTimeout});
    else pass_cnt++;
  endtask

  task automatic test_single();
    bit seen;
    do_reset();
    reqValid = 4'b0001; reqIn1[0] = 16'h3C00; reqIn2[0] = 16'h4000;
    wait_grant(seen);
    total_cnt++;
    if (!seen || reqGrant !== 4'b0001) $display("FAIL single_grant: got %b seen %0d want 0001", reqGrant, seen);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    total_cnt++;
    if ({mulStart, mulIn1, mulIn2} !== {1'b1, 16'h3C00, 16'h4000})
      $display("FAIL single_issue: got %b %h %h want 1 3c00 4000", mulStart, mulIn1, mulIn2);
    else pass_cnt++;
    total_cnt++;
    if (reqGrant !== 4'b0000) $display("FAIL single_grant_pulse: got %b want 0000", reqGrant);
    else pass_cnt++;
    @(posedge clock); #1;
    reqIn1[0] = 16'hFFFF; reqValid = 4'b1110;  // requests change during WAIT
    @(negedge clock);
    total_cnt++;
    if ({mulStart, mulIn1, mulIn2, reqGrant} !== {1'b0, 16'h3C00, 16'h4000, 4'b0000})
      $display("FAIL single_wait_hold: got %b %h %h %b want 0 3c00 4000 0000", mulStart, mulIn1, mulIn2, reqGrant);
    else pass_cnt++;
    pulse_done(16'h4000, 4'h2, 5'h01);
    reqValid = '0;
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut, respCondCodes, respStatus, respTimeout} !== {4'b0001, 16'h4000, 4'h2, 5'h01, 1'b0})
      $display("FAIL single_resp: got %b %h %h %h %b want 0001 4000 2 01 0",
               respValid, respOut, respCondCodes, respStatus, respTimeout);
    else pass_cnt++;
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut, mulIn1, mulStart} !== '0)
      $display("FAIL single_after_resp: got %b %h %h %b want 0", respValid, respOut, mulIn1, mulStart);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    bit seen;
    int e;
    logic [15:0] in1_t [4] = '{16'h3C00, 16'h4000, 16'h4200, 16'hBC00};
    logic [15:0] prod_t [4] = '{16'h4000, 16'h4400, 16'h4600, 16'hC000};
    logic [3:0] want_g;
    do_reset();
    for (int i = 0; i < N; i++) begin
      reqIn1[i] = in1_t[i];
      reqIn2[i] = 16'h4000;
    end
    reqValid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      e = k % 4;
      want_g = '0;
      want_g[e] = 1'b1;
      wait_grant(seen);
      total_cnt++;
      if (!seen || reqGrant !== want_g) $display("FAIL contend_grant%0d: got %b want %b", k, reqGrant, want_g);
      else pass_cnt++;
      @(negedge clock);
      total_cnt++;
      if ({mulStart, mulIn1, mulIn2} !== {1'b1, in1_t[e], 16'h4000})
        $display("FAIL contend_issue%0d: got %b %h %h want 1 %h 4000", k, mulStart, mulIn1, mulIn2, in1_t[e]);
      else pass_cnt++;
      @(negedge clock);
      pulse_done(prod_t[e], 4'(e), 5'(e));
      @(negedge clock);
      total_cnt++;
      if ({respValid, respOut, respCondCodes} !== {want_g, prod_t[e], 4'(e)})
        $display("FAIL contend_resp%0d: got %b %h %h want %b %h %h", k, respValid, respOut, respCondCodes,
                 want_g, prod_t[e], 4'(e));
      else pass_cnt++;
    end
    reqValid = '0;
  endtask

  task automatic test_wrap();
    bit seen;
    do_reset();
    reqValid = 4'b0100; reqIn1[2] = 16'h4200; reqIn2[2] = 16'h4000;
    wait_grant(seen);
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    @(negedge clock);
    pulse_done(16'h4600, 4'h0, 5'h00);
    @(negedge clock);
    total_cnt++;
    if (respValid !== 4'b0100) $display("FAIL wrap_setup_resp: got %b want 0100", respValid);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = 4'b1001; reqIn1[3] = 16'h3800; reqIn2[3] = 16'h4400; reqIn1[0] = 16'h4000; reqIn2[0] = 16'h4000;
    wait_grant(seen);
    total_cnt++;
    if (!seen || reqGrant !== 4'b1000) $display("FAIL wrap_first: got %b want 1000", reqGrant);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = 4'b0001;
    @(negedge clock);
    @(negedge clock);
    pulse_done(16'h4000, 4'h0, 5'h00);
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut} !== {4'b1000, 16'h4000}) $display("FAIL wrap_resp3: got %b %h want 1000 4000", respValid, respOut);
    else pass_cnt++;
    wait_grant(seen);
    total_cnt++;
    if (!seen || reqGrant !== 4'b0001) $display("FAIL wrap_second: got %b want 0001", reqGrant);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    @(negedge clock);
    pulse_done(16'h4400, 4'h0, 5'h00);
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut} !== {4'b0001, 16'h4400}) $display("FAIL wrap_resp0: got %b %h want 0001 4400", respValid, respOut);
    else pass_cnt++;
  endtask

  task automatic test_reset_wait();
    bit seen;
    do_reset();
    // Move the pointer to 3 first so a missing pointer reset is visible.
    reqValid = 4'b0100; reqIn1[2] = 16'h4200; reqIn2[2] = 16'h4000;
    wait_grant(seen);
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    @(negedge clock);
    pulse_done(16'h4600, 4'h0, 5'h00);
    @(posedge clock); #1;
    reqValid = 4'b1000; reqIn1[3] = 16'h3800; reqIn2[3] = 16'h4400;
    wait_grant(seen);
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    @(negedge clock);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; mulDone = 1'b1; mulOut = 16'h1111;
    @(negedge clock);
    total_cnt++;
    if ({respValid, mulStart, mulIn1, respOut} !== '0)
      $display("FAIL rstwait_idle: got %b %b %h %h want 0", respValid, mulStart, mulIn1, respOut);
    else pass_cnt++;
    @(posedge clock); #1;
    mulDone = 1'b0; mulOut = '0;
    reqValid = 4'b1010; reqIn1[1] = 16'h3C00; reqIn2[1] = 16'h4000;
    wait_grant(seen);
    total_cnt++;
    if (!seen || reqGrant !== 4'b0010) $display("FAIL rstwait_grant: got %b want 0010", reqGrant);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    @(negedge clock);
    pulse_done(16'h4000, 4'h1, 5'h02);
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut} !== {4'b0010, 16'h4000}) $display("FAIL rstwait_resp: got %b %h want 0010 4000", respValid, respOut);
    else pass_cnt++;
  endtask

  task automatic test_stray_done();
    bit seen;
    do_reset();
    @(posedge clock); #1;
    mulDone = 1'b1; mulOut = 16'h1234; mulCondCodes = 4'h5; mulStatus = 5'h03;
    @(negedge clock);
    total_cnt++;
    if ({respValid, mulStart} !== 5'd0) $display("FAIL stray_same: got %b %b want 0", respValid, mulStart);
    else pass_cnt++;
    @(posedge clock); #1;
    mulDone = 1'b0; mulOut = '0; mulCondCodes = '0; mulStatus = '0;
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut, respCondCodes} !== '0) $display("FAIL stray_next: got %b %h %h want 0", respValid, respOut, respCondCodes);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = 4'b0001; reqIn1[0] = 16'h4000; reqIn2[0] = 16'h4000;
    wait_grant(seen);
    total_cnt++;
    if (!seen || reqGrant !== 4'b0001) $display("FAIL stray_grant: got %b want 0001", reqGrant);
    else pass_cnt++;
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);
    @(negedge clock);
    pulse_done(16'h4400, 4'h0, 5'h00);
    @(negedge clock);
    total_cnt++;
    if ({respValid, respOut} !== {4'b0001, 16'h4400}) $display("FAIL stray_resp: got %b %h want 0001 4400", respValid, respOut);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit seen;
    int first_k;
    logic [15:0] got_out;
    logic got_tmo;
    do_reset();
    reqValid = 4'b0010; reqIn1[1] = 16'h3C00; reqIn2[1] = 16'h4000;
    wait_grant(seen);
    @(posedge clock); #1;
    reqValid = '0;
    @(negedge clock);  // ISSUE
    first_k = 0; got_out = '0; got_tmo = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clock);
      if (respValid != '0 && first_k == 0) begin
        first_k = k; got_out = respOut; got_tmo = respTimeout;
      end
    end
`ifdef FPU_ARB_TIMEOUT_EN
    total_cnt++;
    if (first_k != 65) $display("FAIL timeout_cycle: got %0d want 65", first_k);
    else pass_cnt++;
    total_cnt++;
    if ({got_out, got_tmo} !== {16'h7E00, 1'b1}) $display("FAIL timeout_resp: got %h %b want 7e00 1", got_out, got_tmo);
    else pass_cnt++;
`else
    total_cnt++;
    if (first_k != 0) $display("FAIL no_timeout: got resp at %0d want none", first_k);
    else pass_cnt++;
    total_cnt++;
    if ({mulIn1, mulIn2, respTimeout} !== {16'h3C00, 16'h4000, 1'b0})
      $display("FAIL no_timeout_hold: got %h %h %b want 3c00 4000 0", mulIn1, mulIn2, respTimeout);
    else pass_cnt++;
`endif
    do_reset();
  endtask

  initial begin
    reset = 1'b1; reqValid = '0; reqIn1 = '0; reqIn2 = '0;
    mulDone = 1'b0; mulOut = '0; mulCondCodes = '0; mulStatus = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_reset_wait();
    test_stray_done();
    test_timeout();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
